// File: rtl/fetch_pkg.sv
// Shared state encoding, constants and PC helper for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch targets are word-aligned: the two low bits are dropped on load.
    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts cycles an instruction request waits for its ack and raises a sticky
// timeout flag once the count reaches MAX_WAIT.
module fetch_wait_timer
    import fetch_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    output logic timeout
);

    localparam logic [4:0] LIMIT = 5'(MAX_WAIT);

    logic [3:0] cnt_r;
    logic       timeout_r;
    logic       waiting_s;
    logic [4:0] cnt_inc_s;

    // A wait cycle is one where the request is up and no ack returns.
    always_comb begin
        waiting_s = req & ~ack;
        cnt_inc_s = {1'b0, cnt_r} + 5'd1;
    end

    // Saturating wait counter, cleared whenever no request is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= 4'd0;
            timeout_r <= 1'b0;
        end else begin
            if (waiting_s) begin
                if (cnt_r != 4'hF) begin
                    cnt_r <= cnt_inc_s[3:0];
                end else begin
                    cnt_r <= cnt_r;
                end
                if (cnt_inc_s >= LIMIT) begin
                    timeout_r <= 1'b1;
                end else begin
                    timeout_r <= timeout_r;
                end
            end else begin
                cnt_r     <= 4'd0;
                timeout_r <= timeout_r;
            end
        end
    end

    assign timeout = timeout_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: requests one word at pc,
// holds it for issue, and handles redirects that arrive mid-request.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic        inst_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        fetch_err
);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic         req_r;
    logic [31:0]  inst_r;
    logic         valid_r;
    logic         pend_r;
    logic [31:0]  pend_pc_r;
    logic         timeout_s;
    logic         accept_s;
    logic [31:0]  target_s;

    // An ack only counts while our own request is actually on the bus.
    always_comb begin
        accept_s = (state_r == FETCH) & req_r & imem_ack;
        target_s = align_pc(redirect_pc);
    end

    // Fetch/issue state machine with all outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= FETCH;
            pc_r      <= RESET_PC;
            req_r     <= 1'b0;
            inst_r    <= 32'h0000_0000;
            valid_r   <= 1'b0;
            pend_r    <= 1'b0;
            pend_pc_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                FETCH: begin
                    if (accept_s) begin
                        // Stale data is dropped whenever a redirect is newer than the request.
                        if (redirect) begin
                            pc_r   <= target_s;
                            pend_r <= 1'b0;
                        end else if (pend_r) begin
                            pc_r   <= pend_pc_r;
                            pend_r <= 1'b0;
                        end else begin
                            inst_r  <= imem_rdata;
                            valid_r <= 1'b1;
                            req_r   <= 1'b0;
                            state_r <= ISSUE;
                        end
                    end else begin
                        req_r <= 1'b1;
                        if (redirect && req_r) begin
                            pend_r    <= 1'b1;
                            pend_pc_r <= target_s;
                        end else if (redirect) begin
                            pc_r <= target_s;
                        end else begin
                            pend_r <= pend_r;
                        end
                    end
                end
                ISSUE: begin
                    if (redirect) begin
                        inst_r  <= 32'h0000_0000;
                        valid_r <= 1'b0;
                        pc_r    <= target_s;
                        req_r   <= 1'b1;
                        state_r <= FETCH;
                    end else if (!stall) begin
                        valid_r <= 1'b0;
                        pc_r    <= pc_r + PC_INC;
                        req_r   <= 1'b1;
                        state_r <= FETCH;
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                default: begin
                    state_r <= FETCH;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    pend_r  <= 1'b0;
                end
            endcase
        end
    end

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_r),
        .ack     (imem_ack),
        .timeout (timeout_s)
    );

    assign imem_req   = req_r;
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign Inst       = inst_r;
    assign inst_valid = valid_r;
    assign fetch_err  = timeout_s;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios plus randomized traffic for fetch_ctrl, checked every cycle
// against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Inst;
    logic        inst_valid;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Inst        (Inst),
        .inst_valid  (inst_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one word in flight, a held word, and a latest-wins redirect slot.
    logic        m_req, m_valid, m_err, m_pend;
    logic [31:0] m_pc, m_inst, m_pend_pc;
    int          m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_req <= 1'b0; m_valid <= 1'b0; m_inst <= 32'h0;
            m_err <= 1'b0; m_pend <= 1'b0; m_pend_pc <= 32'h0; m_wait <= 0;
        end else if (!m_valid) begin
            if (m_req && imem_ack) begin
                m_wait <= 0;
                if (redirect) begin
                    m_pc <= redirect_pc & 32'hFFFF_FFFC;
                    m_pend <= 1'b0;
                end else if (m_pend) begin
                    m_pc <= m_pend_pc;
                    m_pend <= 1'b0;
                end else begin
                    m_inst <= imem_rdata;
                    m_valid <= 1'b1;
                    m_req <= 1'b0;
                end
            end else begin
                if (m_req) begin
                    m_wait <= m_wait + 1;
                    if (m_wait + 1 >= MAXW) m_err <= 1'b1;
                end
                if (redirect && m_req) begin
                    m_pend <= 1'b1;
                    m_pend_pc <= redirect_pc & 32'hFFFF_FFFC;
                end else if (redirect) begin
                    m_pc <= redirect_pc & 32'hFFFF_FFFC;
                end
                m_req <= 1'b1;
            end
        end else if (redirect) begin
            m_valid <= 1'b0;
            m_pc <= redirect_pc & 32'hFFFF_FFFC;
            m_req <= 1'b1;
        end else if (!stall) begin
            m_valid <= 1'b0;
            m_pc <= m_pc + 32'd4;
            m_req <= 1'b1;
        end
    end

    // Compare process: all outputs against the model on every falling edge.
    always @(negedge clk) begin
        chk("imem_req",   32'(imem_req),   32'(m_req));
        chk("imem_addr",  imem_addr,       m_pc);
        chk("pc",         pc,              m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        chk("fetch_err",  32'(fetch_err),  32'(m_err));
        if (m_valid) chk("Inst", Inst, m_inst);
    end

    task automatic step(input logic ack, input logic [31:0] rd, input logic st,
                        input logic rdir, input logic [31:0] rpc);
        imem_ack = ack; imem_rdata = rd; stall = st; redirect = rdir; redirect_pc = rpc;
        @(negedge clk); #1;
    endtask

    initial begin
        @(negedge clk); #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_inst", Inst, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);
        imem_ack = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        // Ack in the first cycle after release must be ignored.
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_ack_ignored", 32'(inst_valid), 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("s1_addr", imem_addr, 32'h0);
        step(1'b1, 32'h2002_0005, 1'b0, 1'b0, 32'h0);
        chk("s1_inst", Inst, 32'h2002_0005);
        chk("s1_valid", 32'(inst_valid), 32'h1);
        chk("s1_req_low", 32'(imem_req), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            chk("s2_inst_hold", Inst, 32'h2002_0005);
            chk("s2_valid_hold", 32'(inst_valid), 32'h1);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("s2_valid_clr", 32'(inst_valid), 32'h0);
        chk("s2_pc", pc, 32'h4);
        chk("s2_req", 32'(imem_req), 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
        chk("s3_addr_kept", imem_addr, 32'h4);
        chk("s3_req_kept", 32'(imem_req), 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("s3_addr_kept2", imem_addr, 32'h4);
        step(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0);
        chk("s3_dropped", 32'(inst_valid), 32'h0);
        chk("s3_new_addr", imem_addr, 32'h0000_0100);
        chk("s3_req", 32'(imem_req), 32'h1);
        step(1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
        chk("s4_inst", Inst, 32'h1111_2222);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
        chk("s4_valid_clr", 32'(inst_valid), 32'h0);
        chk("s4_addr", imem_addr, 32'h40);
        chk("s4_req", 32'(imem_req), 32'h1);
        step(1'b1, 32'h5555_0000, 1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("s6_ack_redir_drop", 32'(inst_valid), 32'h0);
        chk("s6_aligned", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
        chk("s6_valid", 32'(inst_valid), 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("s6_wrap", imem_addr, 32'h0);
        chk("s6_req", 32'(imem_req), 32'h1);
        for (int i = 1; i <= MAXW; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (i == MAXW - 1) chk("s5_err_early", 32'(fetch_err), 32'h0);
            if (i == MAXW) chk("s5_err_set", 32'(fetch_err), 32'h1);
        end
        step(1'b1, 32'h7777_0000, 1'b0, 1'b0, 32'h0);
        chk("s5_err_sticky", 32'(fetch_err), 32'h1);
        chk("s5_valid", 32'(inst_valid), 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("s5_err_sticky2", 32'(fetch_err), 32'h1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("s5_err_rst", 32'(fetch_err), 32'h0);
        chk("s5_req_rst", 32'(imem_req), 32'h0);
        rst_n = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                imem_ack = 1'($urandom_range(0, 1));
                @(negedge clk); #1;
                rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                repeat (MAXW + 1) step(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
            end else begin
                step($urandom_range(0, 9) < 3, $urandom, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 15) == 0, rpc);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
